// File: rtl/audio_cfg_pkg.sv
// Shared WM8731 register map, boot table and FSM encoding for the codec configuration sequencer.
package audio_cfg_pkg;

    localparam int unsigned CFG_LEN = 12;
    localparam int unsigned IDX_W   = 4;

    localparam logic [6:0] R0_LLINE  = 7'h00;
    localparam logic [6:0] R1_RLINE  = 7'h01;
    localparam logic [6:0] R2_LHP    = 7'h02;
    localparam logic [6:0] R3_RHP    = 7'h03;
    localparam logic [6:0] R4_APATH  = 7'h04;
    localparam logic [6:0] R5_DPATH  = 7'h05;
    localparam logic [6:0] R6_PWR    = 7'h06;
    localparam logic [6:0] R7_IFACE  = 7'h07;
    localparam logic [6:0] R8_SRATE  = 7'h08;
    localparam logic [6:0] R9_ACTIVE = 7'h09;
    localparam logic [6:0] R15_RESET = 7'h0F;

    // Reset first, power up everything but outputs, set paths, then I2S/16-bit slave and activate
    localparam logic [15:0] CFG_TABLE [CFG_LEN] = '{
        {R15_RESET, 9'h000}, {R6_PWR,    9'h010}, {R0_LLINE,  9'h017}, {R1_RLINE, 9'h017},
        {R2_LHP,    9'h079}, {R3_RHP,    9'h079}, {R4_APATH,  9'h012}, {R5_DPATH, 9'h000},
        {R7_IFACE,  9'h002}, {R8_SRATE,  9'h000}, {R9_ACTIVE, 9'h001}, {R6_PWR,   9'h000}
    };

    typedef enum logic [2:0] {
        ST_IDLE, ST_ISSUE, ST_WAIT, ST_SETTLE, ST_NEXT, ST_DONE, ST_ERROR
    } cfg_state_e;

endpackage

// File: rtl/audio_codec_cfg_sequencer_if.sv
// Write-request handshake between the configuration sequencer and the I2C write master.
interface audio_codec_cfg_sequencer_if;
    logic        i2c_req;
    logic [15:0] i2c_wdata;
    logic        i2c_ack;
    logic        i2c_nack;

    modport master (output i2c_req, output i2c_wdata, input i2c_ack, input i2c_nack);
    modport slave  (input i2c_req, input i2c_wdata, output i2c_ack, output i2c_nack);
endinterface

// File: rtl/audio_cfg_rom.sv
// Combinational boot-table lookup; indices past the table read as zero flagged last.
module audio_cfg_rom
    import audio_cfg_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [15:0]      word,
    output logic             last
);

    always_comb begin
        word = '0;
        last = 1'b1;
        if (idx < IDX_W'(CFG_LEN)) begin
            word = CFG_TABLE[idx];
            last = (idx == IDX_W'(CFG_LEN - 1));
        end
    end

endmodule

// File: rtl/audio_codec_cfg_sequencer.sv
// WM8731 boot configurator: walks the register table over the I2C write handshake with retries.
// AUDIO_CFG_RUNTIME_WR_EN adds a single-shot host write path usable once the table is done.
module audio_codec_cfg_sequencer
    import audio_cfg_pkg::*;
#(
    parameter int unsigned CLK_FREQ_MHZ = 50,
    parameter int unsigned SETTLE_US    = 100,
    parameter int unsigned RETRY_MAX    = 3,
    parameter int unsigned AUTO_START   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    audio_codec_cfg_sequencer_if.master i2c,
    output logic busy,
    output logic done,
    output logic error,
    output logic xcvr_en
`ifdef AUDIO_CFG_RUNTIME_WR_EN
    ,
    input  logic        host_wr_req,
    input  logic [15:0] host_wr_word,
    output logic        host_wr_ack,
    output logic        host_wr_err
`endif
);

    localparam int unsigned SETTLE_CYC = CLK_FREQ_MHZ * SETTLE_US;
    localparam int unsigned CW         = $clog2(SETTLE_CYC + 1);
    localparam int unsigned RW         = $clog2(RETRY_MAX + 1);

    cfg_state_e       state;
    logic [IDX_W-1:0] idx;
    logic [RW-1:0]    retry;
    logic [RW-1:0]    retry_inc;
    logic [CW-1:0]    cnt;
    logic             auto_pend;
    logic [15:0]      rom_word;
    logic             rom_last;
`ifdef AUDIO_CFG_RUNTIME_WR_EN
    logic             host_pend;
    logic             host_mode;
    logic [15:0]      host_word;
`endif

    assign retry_inc = retry + RW'(1);
    assign xcvr_en   = done;

    audio_cfg_rom u_rom (
        .idx  (idx),
        .word (rom_word),
        .last (rom_last)
    );

    // Sequencer FSM; retry==0 on leaving SETTLE means the settle followed an acked reset word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            i2c.i2c_req   <= 1'b0;
            i2c.i2c_wdata <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            idx           <= '0;
            retry         <= '0;
            cnt           <= '0;
            auto_pend     <= (AUTO_START != 0);
`ifdef AUDIO_CFG_RUNTIME_WR_EN
            host_pend     <= 1'b0;
            host_mode     <= 1'b0;
            host_word     <= '0;
            host_wr_ack   <= 1'b0;
            host_wr_err   <= 1'b0;
`endif
        end else begin
`ifdef AUDIO_CFG_RUNTIME_WR_EN
            host_wr_ack <= 1'b0;
            if (host_wr_req && !host_pend) begin
                host_pend <= 1'b1;
                host_word <= host_wr_word;
            end
`endif
            case (state)
                ST_IDLE: begin
                    if (start || auto_pend) begin
                        auto_pend <= 1'b0;
                        idx       <= '0;
                        retry     <= '0;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
`ifdef AUDIO_CFG_RUNTIME_WR_EN
                    i2c.i2c_wdata <= host_mode ? host_word : rom_word;
`else
                    i2c.i2c_wdata <= rom_word;
`endif
                    i2c.i2c_req   <= 1'b1;
                    state         <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i2c.i2c_ack || i2c.i2c_nack) begin
                        i2c.i2c_req <= 1'b0;
                        cnt         <= '0;
`ifdef AUDIO_CFG_RUNTIME_WR_EN
                        if (host_mode) begin
                            host_mode   <= 1'b0;
                            host_wr_ack <= 1'b1;
                            host_wr_err <= i2c.i2c_nack;
                            busy        <= 1'b0;
                            state       <= ST_DONE;
                        end else
`endif
                        if (i2c.i2c_nack) begin
                            retry <= retry_inc;
                            if (retry_inc == RW'(RETRY_MAX)) begin
                                busy  <= 1'b0;
                                error <= 1'b1;
                                state <= ST_ERROR;
                            end else begin
                                state <= ST_SETTLE;
                            end
                        end else begin
                            retry <= '0;
                            state <= (idx == '0) ? ST_SETTLE : ST_NEXT;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt == CW'(SETTLE_CYC - 1)) begin
                        cnt   <= '0;
                        state <= (retry == '0) ? ST_NEXT : ST_ISSUE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_NEXT: begin
                    if (rom_last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= ST_ISSUE;
                    end
                end
                ST_DONE, ST_ERROR: begin
                    if (start) begin
                        idx   <= '0;
                        retry <= '0;
                        done  <= 1'b0;
                        error <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_ISSUE;
                    end
`ifdef AUDIO_CFG_RUNTIME_WR_EN
                    else if (state == ST_DONE && host_pend) begin
                        host_pend <= 1'b0;
                        host_mode <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_ISSUE;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_codec_cfg_sequencer.sv
// Bench for audio_codec_cfg_sequencer: I2C master BFM with programmable NACKs, checked against a table-walk model.
module tb_audio_codec_cfg_sequencer;

    localparam int RETRY_MAX = 3;
    localparam logic [15:0] TBL [12] = '{
        16'h1E00, 16'h0C10, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
        16'h0812, 16'h0A00, 16'h0E02, 16'h1000, 16'h1201, 16'h0C00
    };

    logic clk, rst_n, start;
    logic busy, done, error, xcvr_en;
`ifdef AUDIO_CFG_RUNTIME_WR_EN
    logic        host_wr_req;
    logic [15:0] host_wr_word;
    logic        host_wr_ack, host_wr_err;
`endif

    audio_codec_cfg_sequencer_if i2c_bus ();

    audio_codec_cfg_sequencer #(
        .CLK_FREQ_MHZ (50),
        .SETTLE_US    (1),
        .RETRY_MAX    (RETRY_MAX),
        .AUTO_START   (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .i2c     (i2c_bus),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .xcvr_en (xcvr_en)
`ifdef AUDIO_CFG_RUNTIME_WR_EN
        ,
        .host_wr_req  (host_wr_req),
        .host_wr_word (host_wr_word),
        .host_wr_ack  (host_wr_ack),
        .host_wr_err  (host_wr_err)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [15:0] nack_word;
    int          nack_left;
    int          ack_dly;
    bit          rand_dly;
    logic [15:0] log_q [$];
    int          gap_q [$];
    int          unstable;
    int          last_resp_cyc;

    logic [15:0] exp_q [$];
    bit          exp_settle [$];
    bit          exp_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // I2C write master BFM: responds to each request after a delay, NACKing per policy
    initial begin : bfm
        logic [15:0] cur;
        int          cnt;
        bit          pend;
        i2c_bus.i2c_ack  = 1'b0;
        i2c_bus.i2c_nack = 1'b0;
        pend = 1'b0;
        cnt  = 0;
        cur  = '0;
        forever begin
            @(negedge clk);
            i2c_bus.i2c_ack  = 1'b0;
            i2c_bus.i2c_nack = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else if (pend) begin
                if (i2c_bus.i2c_req !== 1'b1 || i2c_bus.i2c_wdata !== cur) unstable++;
                cnt--;
                if (cnt <= 0) begin
                    if (cur == nack_word && nack_left != 0) begin
                        i2c_bus.i2c_nack = 1'b1;
                        i2c_bus.i2c_ack  = 1'($urandom_range(0, 1));
                        if (nack_left > 0) nack_left--;
                    end else begin
                        i2c_bus.i2c_ack = 1'b1;
                    end
                    pend = 1'b0;
                    last_resp_cyc = cyc + 1;
                end
            end else if (i2c_bus.i2c_req === 1'b1) begin
                pend = 1'b1;
                cur  = i2c_bus.i2c_wdata;
                cnt  = rand_dly ? int'($urandom_range(1, 6)) : ack_dly;
                log_q.push_back(cur);
                gap_q.push_back(cyc - last_resp_cyc);
            end
        end
    end

    // Reference: expected write sequence for a given NACK policy; settle flag marks a gap of ~50 cycles
    task automatic model(input logic [15:0] nw, input int nl);
        int left;
        bit prev;
        int tries;
        bit acked;
        left = nl;
        prev = 1'b0;
        exp_err = 1'b0;
        exp_q.delete();
        exp_settle.delete();
        for (int i = 0; i < 12 && !exp_err; i++) begin
            tries = 0;
            acked = 1'b0;
            while (!acked && !exp_err) begin
                exp_q.push_back(TBL[i]);
                exp_settle.push_back(prev);
                tries++;
                if (TBL[i] == nw && left != 0) begin
                    if (left > 0) left--;
                    prev = 1'b1;
                    if (tries == RETRY_MAX) exp_err = 1'b1;
                end else begin
                    acked = 1'b1;
                    prev  = (i == 0);
                end
            end
        end
    endtask

    task automatic clear_log();
        log_q.delete();
        gap_q.delete();
        unstable = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(output bit to);
        int k;
        k = 0;
        while (!(done || error) && k < 4000) begin
            @(negedge clk);
            k++;
        end
        to = (k >= 4000);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (i2c_bus.i2c_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", i2c_bus.i2c_req); end
        n_chk++; if (i2c_bus.i2c_wdata !== 16'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0000", i2c_bus.i2c_wdata); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_chk++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", error); end
        n_chk++; if (xcvr_en !== 1'b0) begin n_fail++; $display("FAIL reset_xcvr_en: got %b expected 0", xcvr_en); end
        clear_log();
        rst_n = 1'b1;
    endtask

    task automatic test_auto_table();
        bit to;
        model(16'hFFFF, 0);
        wait_end(to);
        n_chk++; if (to) begin n_fail++; $display("FAIL auto_timeout: done/error never rose"); end
        n_chk++; if (log_q.size() != exp_q.size()) begin n_fail++; $display("FAIL auto_count: got %0d writes expected %0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_chk++; if (log_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL auto_word%0d: got %h expected %h", i, log_q[i], exp_q[i]); end
            if (i > 0) begin
                n_chk++;
                if (exp_settle[i] ? (gap_q[i] < 50 || gap_q[i] > 55) : (gap_q[i] != 2)) begin
                    n_fail++; $display("FAIL auto_gap%0d: got %0d cycles expected %s", i, gap_q[i], exp_settle[i] ? "50..55" : "2");
                end
            end
        end
        n_chk++; if (done !== 1'b1 || xcvr_en !== 1'b1) begin n_fail++; $display("FAIL auto_done: got done=%b xcvr_en=%b expected 1/1", done, xcvr_en); end
        n_chk++; if (busy !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL auto_idle: got busy=%b error=%b expected 0/0", busy, error); end
        n_chk++; if (unstable != 0) begin n_fail++; $display("FAIL auto_stable: got %0d unstable cycles expected 0", unstable); end
    endtask

    task automatic test_restart_nack_retry();
        bit to;
        nack_word = 16'h0479; nack_left = 1; rand_dly = 1'b1;
        model(nack_word, 1);
        clear_log();
        pulse_start();
        n_chk++; if (xcvr_en !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL restart_flags: got xcvr_en=%b done=%b busy=%b expected 0/0/1", xcvr_en, done, busy);
        end
        wait_end(to);
        n_chk++; if (to) begin n_fail++; $display("FAIL retry_timeout: done/error never rose"); end
        n_chk++; if (log_q.size() != exp_q.size()) begin n_fail++; $display("FAIL retry_count: got %0d writes expected %0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_chk++; if (log_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL retry_word%0d: got %h expected %h", i, log_q[i], exp_q[i]); end
            if (i > 0) begin
                n_chk++;
                if (exp_settle[i] ? (gap_q[i] < 50 || gap_q[i] > 55) : (gap_q[i] != 2)) begin
                    n_fail++; $display("FAIL retry_gap%0d: got %0d cycles expected %s", i, gap_q[i], exp_settle[i] ? "50..55" : "2");
                end
            end
        end
        n_chk++; if (error !== 1'b0 || done !== 1'b1 || xcvr_en !== 1'b1) begin
            n_fail++; $display("FAIL retry_status: got error=%b done=%b xcvr_en=%b expected 0/1/1", error, done, xcvr_en);
        end
    endtask

    task automatic test_nack_error();
        bit to;
        int n0e02, n1000;
        nack_word = 16'h0E02; nack_left = -1; rand_dly = 1'b1;
        model(nack_word, -1);
        clear_log();
        pulse_start();
        wait_end(to);
        n_chk++; if (to) begin n_fail++; $display("FAIL err_timeout: done/error never rose"); end
        n_chk++; if (log_q.size() != exp_q.size()) begin n_fail++; $display("FAIL err_count: got %0d writes expected %0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_chk++; if (log_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL err_word%0d: got %h expected %h", i, log_q[i], exp_q[i]); end
        end
        n0e02 = 0; n1000 = 0;
        foreach (log_q[i]) begin
            if (log_q[i] == 16'h0E02) n0e02++;
            if (log_q[i] == 16'h1000) n1000++;
        end
        n_chk++; if (n0e02 != RETRY_MAX) begin n_fail++; $display("FAIL err_attempts: got %0d attempts at 0E02 expected %0d", n0e02, RETRY_MAX); end
        n_chk++; if (n1000 != 0) begin n_fail++; $display("FAIL err_no_1000: got %0d writes of 1000 expected 0", n1000); end
        repeat (3) @(negedge clk);
        n_chk++; if (error !== 1'b1 || xcvr_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL err_status: got error=%b xcvr_en=%b done=%b busy=%b expected 1/0/0/0", error, xcvr_en, done, busy);
        end
    endtask

    task automatic test_start_ignored();
        int k;
        nack_word = 16'hFFFF; nack_left = 0; rand_dly = 1'b1;
        model(nack_word, 0);
        clear_log();
        pulse_start();
        n_chk++; if (error !== 1'b0) begin n_fail++; $display("FAIL start_clears_error: got %b expected 0", error); end
        k = 0;
        while (!(done || error) && k < 4000) begin
            @(negedge clk);
            start = i2c_bus.i2c_req && ($urandom_range(0, 2) == 0);
            k++;
        end
        start = 1'b0;
        n_chk++; if (k >= 4000) begin n_fail++; $display("FAIL ignore_timeout: done/error never rose"); end
        n_chk++; if (log_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ignore_count: got %0d writes expected %0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_chk++; if (log_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ignore_word%0d: got %h expected %h", i, log_q[i], exp_q[i]); end
        end
        n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL ignore_done: got %b expected 1", done); end
    endtask

    task automatic test_random_nacks();
        bit to;
        int nl;
        for (int r = 0; r < 4; r++) begin
            nack_word = TBL[$urandom_range(0, 11)];
            nl = int'($urandom_range(0, 3));
            nack_left = nl; rand_dly = 1'b1;
            model(nack_word, nl);
            clear_log();
            pulse_start();
            wait_end(to);
            repeat (2) @(negedge clk);
            n_chk++; if (to) begin n_fail++; $display("FAIL rand%0d_timeout: done/error never rose", r); end
            n_chk++; if (log_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d writes expected %0d (word %h x%0d)", r, log_q.size(), exp_q.size(), nack_word, nl); end
            for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
                n_chk++; if (log_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_word%0d: got %h expected %h", r, i, log_q[i], exp_q[i]); end
            end
            n_chk++; if (error !== exp_err || done !== !exp_err || xcvr_en !== !exp_err) begin
                n_fail++; $display("FAIL rand%0d_status: got error=%b done=%b xcvr_en=%b expected error=%b", r, error, done, xcvr_en, exp_err);
            end
            n_chk++; if (unstable != 0) begin n_fail++; $display("FAIL rand%0d_stable: got %0d unstable cycles expected 0", r, unstable); end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int k;
        nack_word = 16'hFFFF; nack_left = 0; rand_dly = 1'b1;
        clear_log();
        pulse_start();
        k = 0;
        do begin
            @(negedge clk);
            #2;
            k++;
        end while (!(log_q.size() >= 4 && i2c_bus.i2c_req === 1'b1) && k < 4000);
        n_chk++; if (k >= 4000) begin n_fail++; $display("FAIL rstmid_setup: request never seen"); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (i2c_bus.i2c_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req: got %b expected 0 before next edge", i2c_bus.i2c_req); end
        n_chk++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || xcvr_en !== 1'b0 || i2c_bus.i2c_wdata !== 16'h0) begin
            n_fail++; $display("FAIL rstmid_outputs: got busy=%b done=%b error=%b xcvr_en=%b wdata=%h expected all 0", busy, done, error, xcvr_en, i2c_bus.i2c_wdata);
        end
        repeat (2) @(negedge clk);
        model(nack_word, 0);
        clear_log();
        rst_n = 1'b1;
        wait_end(to);
        n_chk++; if (to) begin n_fail++; $display("FAIL rstmid_timeout: rerun never finished"); end
        n_chk++; if (log_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rstmid_count: got %0d writes expected %0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_chk++; if (log_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_word%0d: got %h expected %h", i, log_q[i], exp_q[i]); end
        end
        n_chk++; if (done !== 1'b1 || xcvr_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_done: got done=%b xcvr_en=%b expected 1/1", done, xcvr_en); end
    endtask

`ifdef AUDIO_CFG_RUNTIME_WR_EN
    task automatic test_host_wr();
        int  k;
        bit  xcvr_low;
        bit  got_err;
        nack_word = 16'hFFFF; nack_left = 0; rand_dly = 1'b1;
        clear_log();
        xcvr_low = 1'b0;
        @(negedge clk);
        host_wr_req  = 1'b1;
        host_wr_word = 16'h0C1F;
        @(negedge clk);
        host_wr_req  = 1'b0;
        k = 0;
        got_err = 1'b1;
        while (host_wr_ack !== 1'b1 && k < 200) begin
            if (xcvr_en !== 1'b1) xcvr_low = 1'b1;
            @(negedge clk);
            k++;
        end
        got_err = host_wr_err;
        n_chk++; if (k >= 200) begin n_fail++; $display("FAIL host_ack: got no host_wr_ack expected one pulse"); end
        n_chk++; if (got_err !== 1'b0) begin n_fail++; $display("FAIL host_err: got %b expected 0", got_err); end
        n_chk++; if (log_q.size() != 1) begin n_fail++; $display("FAIL host_count: got %0d writes expected 1", log_q.size()); end
        if (log_q.size() >= 1) begin
            n_chk++; if (log_q[0] !== 16'h0C1F) begin n_fail++; $display("FAIL host_word: got %h expected 0C1F", log_q[0]); end
        end
        repeat (3) @(negedge clk);
        n_chk++; if (xcvr_low || xcvr_en !== 1'b1 || done !== 1'b1) begin
            n_fail++; $display("FAIL host_xcvr: got xcvr_low=%b xcvr_en=%b done=%b expected 0/1/1", xcvr_low, xcvr_en, done);
        end
    endtask
`endif

    initial begin
        nack_word = 16'hFFFF;
        nack_left = 0;
        ack_dly = 3;
        rand_dly = 1'b0;
        unstable = 0;
        last_resp_cyc = 0;
`ifdef AUDIO_CFG_RUNTIME_WR_EN
        host_wr_req  = 1'b0;
        host_wr_word = 16'h0;
`endif
        test_reset();
        test_auto_table();
        test_restart_nack_retry();
        test_nack_error();
        test_start_ignored();
        test_random_nacks();
        test_reset_mid();
`ifdef AUDIO_CFG_RUNTIME_WR_EN
        test_host_wr();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
